// File: rtl/irq_pkg.sv
// Shared types, register offsets and helpers for the interrupt controller.
package irq_pkg;

  // Width of a source index / vector number (supports up to 15 sources).
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACTIVE  = 2'd2
  } irq_state_t;

  // Byte offsets of the registers inside the window.
  localparam logic [63:0] OFF_PENDING = 64'h00;
  localparam logic [63:0] OFF_ENABLE  = 64'h08;
  localparam logic [63:0] OFF_ACTIVE  = 64'h10;

  // Vector number meaning "no interrupt presented".
  localparam logic [IDX_W-1:0] VEC_NONE = '0;

  // Source i is presented to the core as vector i+1.
  function automatic logic [IDX_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the
// index of the lowest set request.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge capture into pending bits, enable masking,
// fixed-priority selection and a present/taken/completed handshake with the
// core, plus a small memory-mapped register window.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic [3:0]         interrupt_vector,
  input  logic               irq_ack,
  input  logic               irq_done,
  input  logic [63:0]        bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data,
  output logic               bus_read_valid
);

  irq_state_t           state_q;
  logic [IDX_W-1:0]     sel_q;
  logic [IDX_W-1:0]     vec_q;
  logic [NUM_SRC-1:0]   irq_prev_q;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   enable_q, enable_d;
  logic [63:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic                 hit_pend, hit_en, hit_act;
  logic                 wr_pend, wr_en;
  logic [NUM_SRC-1:0]   wdata_src;
  logic [NUM_SRC-1:0]   edge_set;
  logic [NUM_SRC-1:0]   sel_mask;
  logic                 ack_take, withdraw;
  logic                 enc_any;
  logic [IDX_W-1:0]     enc_idx;
  logic [63:0]          active_view;
  logic                 unused_wdata;

  assign unused_wdata = ^bus_write_data;

  assign hit_pend  = (bus_address == BASE_ADDR + OFF_PENDING);
  assign hit_en    = (bus_address == BASE_ADDR + OFF_ENABLE);
  assign hit_act   = (bus_address == BASE_ADDR + OFF_ACTIVE);
  assign wr_pend   = bus_write_enable & hit_pend;
  assign wr_en     = bus_write_enable & hit_en;
  assign wdata_src = bus_write_data[NUM_SRC-1:0];

  // A level already high when reset releases is seen as an edge because
  // irq_prev comes out of reset at 0.
  assign edge_set = irq_in & ~irq_prev_q;

  // One-hot mask of the source currently latched by the FSM.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_mask[i] = (sel_q == IDX_W'(i));
    end
  end

  // Ack wins over a simultaneous withdraw; done is only meaningful in ACTIVE.
  assign ack_take = (state_q == ST_PRESENT) & irq_ack;
  assign withdraw = (state_q == ST_PRESENT) & ~irq_ack & wr_en &
                    (|(sel_mask & ~wdata_src));

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req_i (pending_q & enable_q),
    .any_o (enc_any),
    .idx_o (enc_idx)
  );

  // Next pending/enable: clears first, then new edges so a set beats a W1C.
  always_comb begin
    pending_d = pending_q;
    if (wr_pend)  pending_d = pending_d & ~wdata_src;
    if (ack_take) pending_d = pending_d & ~sel_mask;
    pending_d = pending_d | edge_set;
    enable_d  = wr_en ? wdata_src : enable_q;
  end

  assign active_view = (state_q == ST_IDLE) ? 64'd0
                       : {58'd0, state_q, vec_of(sel_q)};

  // Read mux samples pre-write register contents; a miss returns 0, no valid.
  always_comb begin
    rdata_d  = 64'd0;
    rvalid_d = 1'b0;
    if (bus_read_enable) begin
      if (hit_pend) begin
        rdata_d  = {{(64-NUM_SRC){1'b0}}, pending_q};
        rvalid_d = 1'b1;
      end else if (hit_en) begin
        rdata_d  = {{(64-NUM_SRC){1'b0}}, enable_q};
        rvalid_d = 1'b1;
      end else if (hit_act) begin
        rdata_d  = active_view;
        rvalid_d = 1'b1;
      end
    end
  end

  // Source history, pending/enable registers and registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      enable_q   <= '1;
      rdata_q    <= 64'd0;
      rvalid_q   <= 1'b0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Present/taken/completed sequencing with a registered vector output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      vec_q   <= VEC_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enc_any) begin
            sel_q   <= enc_idx;
            vec_q   <= vec_of(enc_idx);
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack_take) begin
            vec_q   <= VEC_NONE;
            state_q <= ST_ACTIVE;
          end else if (withdraw) begin
            vec_q   <= VEC_NONE;
            state_q <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (irq_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          vec_q   <= VEC_NONE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupt_vector = vec_q;
  assign bus_read_data    = rdata_q;
  assign bus_read_valid   = rvalid_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a register-access table followed by
// hand-written interrupt handshake sequences.
module tb_irq_controller;

  localparam logic [63:0] BASE   = 64'h8000_0020;
  localparam logic [63:0] A_PEND = BASE + 64'h00;
  localparam logic [63:0] A_EN   = BASE + 64'h08;
  localparam logic [63:0] A_ACT  = BASE + 64'h10;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_in;
  logic [3:0]  interrupt_vector;
  logic        irq_ack;
  logic        irq_done;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic        bus_read_valid;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NUM_SRC(4), .BASE_ADDR(BASE)) dut (
    .clk              (clk),
    .reset            (reset),
    .irq_in           (irq_in),
    .interrupt_vector (interrupt_vector),
    .irq_ack          (irq_ack),
    .irq_done         (irq_done),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .bus_read_valid   (bus_read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_valid;
  } bus_vec_t;

  bus_vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [63:0] addr, input logic [63:0] data);
    bus_address      = addr;
    bus_write_data   = data;
    bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [63:0] addr, input logic [63:0] exp);
    bus_address     = addr;
    bus_read_enable = 1'b1;
    tick();
    bus_read_enable = 1'b0;
    check(name, bus_read_data, exp);
    check({name, "_valid"}, {63'd0, bus_read_valid}, 64'd1);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic chk_vec(input string name, input logic [3:0] exp);
    check(name, {60'd0, interrupt_vector}, {60'd0, exp});
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, A_EN,               64'd0,                  64'hF, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, A_PEND,             64'd0,                  64'h0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, A_ACT,              64'd0,                  64'h0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, BASE + 64'h18,      64'd0,                  64'h0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, A_EN,               64'h5,                  64'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, A_EN,               64'd0,                  64'h5, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, A_EN,               64'hFFFF_FFFF_FFFF_FFF3, 64'h5, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, A_EN,               64'd0,                  64'h3, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, BASE + 64'h18,      64'hF,                  64'h0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, A_EN,               64'hF,                  64'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, A_EN,               64'd0,                  64'hF, 1'b1};
    tbl[11] = '{1'b0, 1'b1, BASE + 64'h20,      64'd0,                  64'h0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, BASE + 64'h01,      64'd0,                  64'h0, 1'b0};

    reset            = 1'b0;
    irq_in           = '0;
    irq_ack          = 1'b0;
    irq_done         = 1'b0;
    bus_address      = '0;
    bus_write_data   = '0;
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_vec("rst_vec", 4'd0);
    check("rst_rdata", bus_read_data, 64'd0);
    check("rst_rvalid", {63'd0, bus_read_valid}, 64'd0);
    reset = 1'b1;
    tick();
    chk_vec("post_rst_vec", 4'd0);

    // Register access table (no interrupt activity)
    for (int i = 0; i < 13; i++) begin
      bus_address      = tbl[i].addr;
      bus_write_data   = tbl[i].wdata;
      bus_write_enable = tbl[i].wr;
      bus_read_enable  = tbl[i].rd;
      tick();
      bus_write_enable = 1'b0;
      bus_read_enable  = 1'b0;
      check($sformatf("tbl%0d_data", i), bus_read_data, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_valid", i), {63'd0, bus_read_valid}, {63'd0, tbl[i].exp_valid});
    end

    // Single pulse on source 0: two-cycle latency, held until ack
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    chk_vec("s1_lat1", 4'd0);
    tick();
    chk_vec("s1_lat2", 4'd1);
    repeat (3) tick();
    chk_vec("s1_hold", 4'd1);
    pulse_ack();
    chk_vec("s1_ack", 4'd0);
    rd_chk("s1_pend_clr", A_PEND, 64'h0);
    rd_chk("s1_active", A_ACT, 64'h21);
    pulse_done();
    rd_chk("s1_idle", A_ACT, 64'h0);
    pulse_ack();
    rd_chk("s1_ack_ignored", A_ACT, 64'h0);

    // Two sources rising together: lowest index first
    irq_in = 4'b0110;
    tick();
    irq_in = 4'b0000;
    chk_vec("s2_lat1", 4'd0);
    tick();
    chk_vec("s2_first", 4'd2);
    pulse_ack();
    chk_vec("s2_ack", 4'd0);
    pulse_done();
    chk_vec("s2_idle_gap", 4'd0);
    tick();
    chk_vec("s2_second", 4'd3);
    pulse_ack();
    pulse_done();
    tick();
    tick();
    chk_vec("s2_none", 4'd0);

    // Masked source stays pending, presented once enabled
    bus_wr(A_EN, 64'hE);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    chk_vec("s3_masked", 4'd0);
    rd_chk("s3_pend", A_PEND, 64'h1);
    bus_wr(A_EN, 64'hF);
    chk_vec("s3_en_edge", 4'd0);
    tick();
    chk_vec("s3_unmasked", 4'd1);
    pulse_ack();
    pulse_done();
    tick();
    chk_vec("s3_clean", 4'd0);

    // W1C while masked removes the request before it is ever presented
    bus_wr(A_EN, 64'hE);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    bus_wr(A_PEND, 64'h1);
    bus_wr(A_EN, 64'hF);
    tick();
    tick();
    chk_vec("s3_w1c_novec", 4'd0);
    rd_chk("s3_w1c_pend", A_PEND, 64'h0);

    // Withdraw in PRESENT by disabling the selected source
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    chk_vec("s4_present", 4'd1);
    rd_chk("s4_act_present", A_ACT, 64'h11);
    bus_wr(A_EN, 64'hE);
    chk_vec("s4_withdrawn", 4'd0);
    rd_chk("s4_act_idle", A_ACT, 64'h0);
    rd_chk("s4_pend_kept", A_PEND, 64'h1);
    bus_wr(A_EN, 64'hF);
    chk_vec("s4_reen_edge", 4'd0);
    tick();
    chk_vec("s4_represent", 4'd1);

    // Ack and done together: ack taken, done ignored
    irq_ack  = 1'b1;
    irq_done = 1'b1;
    tick();
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    chk_vec("s5_ackdone_vec", 4'd0);
    rd_chk("s5_ackdone_act", A_ACT, 64'h21);

    // New edge on the active source: pending, not presented until done
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    chk_vec("s5_no_nest", 4'd0);
    rd_chk("s5_pend_re", A_PEND, 64'h1);
    pulse_done();
    chk_vec("s5_done_gap", 4'd0);
    tick();
    chk_vec("s5_repres", 4'd1);

    // Edge and W1C on the same bit in the same cycle: set wins
    pulse_ack();
    irq_in = 4'b0001;
    bus_wr(A_PEND, 64'h1);
    irq_in = 4'b0000;
    rd_chk("s5_set_wins", A_PEND, 64'h1);
    pulse_done();
    tick();
    chk_vec("s6_present", 4'd1);

    // Asynchronous reset in PRESENT
    #2;
    reset = 1'b0;
    #1;
    chk_vec("s6_async_vec", 4'd0);
    check("s6_async_rvalid", {63'd0, bus_read_valid}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_vec("s6_after_vec", 4'd0);
    rd_chk("s6_pend", A_PEND, 64'h0);
    rd_chk("s6_en", A_EN, 64'hF);

    // Read miss at BASE+0x18
    bus_address     = BASE + 64'h18;
    bus_read_enable = 1'b1;
    tick();
    bus_read_enable = 1'b0;
    check("miss_valid", {63'd0, bus_read_valid}, 64'd0);
    check("miss_data", bus_read_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
